spi_flash_responder: RTL and testbench

//  SPI-mode-0 serial-flash responder: the device end of the bit-banged flash bus (SCK/MOSI/CS/MISO).

---
 rtl/spi_flash_responder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial-flash device answering READ/RDID/RDSR from a byte memory.
// All SPI pins are oversampled in the clk domain; rev 1.0.
`default_nettype none

module spi_flash_responder #(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              selected
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_READ   = 3'd3,
    S_ID     = 3'd4,
    S_SR     = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync_q;
  logic [2:0]        cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  // Holds one bit less than the address: the final bit comes straight from mosi at capture.
  logic [ADDR_W-2:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        tx_q, tx_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic              load_q, load_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_active, mosi_s;

  assign cs_active = ~cs_sync_q[1];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign sck_rise  = cs_active & sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = cs_active & ~sck_sync_q[1] & sck_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      tx_q        <= '0;
      id_idx_q    <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      tx_q        <= tx_d;
      id_idx_q    <= id_idx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      mem_rd_q    <= mem_rd_d;
      load_q      <= load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    tx_d       = tx_q;
    id_idx_d   = id_idx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    mem_rd_d   = 1'b0;
    load_d     = mem_rd_q;

    unique case (state_q)
      S_CMD: begin
        if (sck_rise) begin
          shift_d   = {shift_q[ADDR_W-3:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            unique case ({shift_q[6:0], mosi_s})
              8'h03: state_d = S_ADDR;
              8'h9F: begin
                state_d  = S_ID;
                tx_d     = JEDEC_ID[23:16];
                id_idx_d = 2'd1;
              end
              8'h05: begin
                state_d = S_SR;
                tx_d    = 8'h00;
              end
              default: state_d = S_IGNORE;
            endcase
          end
        end
      end

      S_ADDR: begin
        if (sck_rise) begin
          shift_d   = {shift_q[ADDR_W-3:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = '0;
            mem_rd_d   = 1'b1;
            mem_addr_d = {shift_q, mosi_s};
            addr_d     = {shift_q, mosi_s};
            state_d    = S_READ;
          end
        end
      end

      S_READ, S_ID, S_SR: begin
        if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          oe_d   = 1'b1;
        end
        // The 8th rise closes a byte; the next one must be in tx before the following fall.
        if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (state_q == S_READ) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_q;
            end else if (state_q == S_ID) begin
              unique case (id_idx_q)
                2'd1: begin
                  tx_d     = JEDEC_ID[15:8];
                  id_idx_d = 2'd2;
                end
                2'd2: begin
                  tx_d     = JEDEC_ID[7:0];
                  id_idx_d = 2'd3;
                end
                default: tx_d = 8'hFF;
              endcase
            end else begin
              tx_d = 8'h00;
            end
          end
        end
      end

      default: ;
    endcase

    if (load_q && state_q == S_READ) begin
      tx_d   = mem_rdata;
      addr_d = addr_q + ADDR_W'(1);
    end

    if (cs_fall) begin
      state_d   = S_CMD;
      bit_cnt_d = '0;
    end

    if (cs_rise) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      miso_d    = 1'b0;
      mem_rd_d  = 1'b0;
      load_d    = 1'b0;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign selected    = cs_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI master frames against spi_flash_responder with a
// behavioural byte memory (mem[i] = i ^ 8'h5A) answering one clk after mem_rd.
`default_nettype none

module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        resetq;
  logic        sck, cs_n, mosi;
  logic        miso, oe, mem_rd, selected;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int PH     = 5;
  int rd_count = 0;
  logic [15:0] rd_log [0:63];

  spi_flash_responder #(.ADDR_W(16), .JEDEC_ID(24'hEF4016)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .spi_sck     (sck),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (oe),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .selected    (selected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem_addr[7:0] ^ 8'h5A;
      if (rd_count < 64) rd_log[rd_count] = mem_addr;
      rd_count = rd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts out nbits MSB first, sampling miso just before each rising SCK.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                      output logic oe_and, output logic oe_or);
    rx = 8'h00; oe_and = 1'b1; oe_or = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      clocks(PH);
      rx = {rx[6:0], miso};
      oe_and = oe_and & oe;
      oe_or  = oe_or | oe;
      sck = 1'b1;
      clocks(PH);
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    clocks(PH);
  endtask

  task automatic frame_end();
    clocks(PH);
    cs_n = 1'b1;
    clocks(6);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    logic a, o;
    xfer(b, 8, r, a, o);
  endtask

  initial begin
    logic [7:0] rx;
    logic oa, oo;
    int base;
    logic [7:0] exp_id [0:4];
    logic [7:0] exp_rd [0:3];
    exp_id[0] = 8'hEF; exp_id[1] = 8'h40; exp_id[2] = 8'h16; exp_id[3] = 8'hFF; exp_id[4] = 8'hFF;
    exp_rd[0] = 8'h4A; exp_rd[1] = 8'h4B; exp_rd[2] = 8'h48; exp_rd[3] = 8'h49;

    resetq = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    clocks(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_selected", 32'(selected), 32'd0);
    resetq = 1'b1;
    clocks(4);

    // Reset in the middle of a READ data byte
    frame_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h20);
    xfer(8'h00, 8, rx, oa, oo);
    check("t1_byte0", 32'(rx), 32'h7A);
    check("t1_sel", 32'(selected), 32'd1);
    xfer(8'h00, 3, rx, oa, oo);
    resetq = 1'b0;
    #1;
    check("t1_miso", 32'(miso), 32'd0);
    check("t1_oe", 32'(oe), 32'd0);
    check("t1_mem_rd", 32'(mem_rd), 32'd0);
    check("t1_mem_addr", 32'(mem_addr), 32'd0);
    check("t1_selected", 32'(selected), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    cs_n = 1'b1;
    clocks(6);

    // RDID: 5 bytes after the opcode
    base = rd_count;
    frame_begin();
    xfer(8'h9F, 8, rx, oa, oo);
    check("t2_cmd_oe", 32'(oo), 32'd0);
    for (int i = 0; i < 5; i++) begin
      xfer(8'h00, 8, rx, oa, oo);
      check($sformatf("t2_id%0d", i), 32'(rx), 32'(exp_id[i]));
      check($sformatf("t2_oe%0d", i), 32'(oa), 32'd1);
    end
    frame_end();
    check("t2_oe_after", 32'(oe), 32'd0);
    check("t2_miso_after", 32'(miso), 32'd0);
    check("t2_no_rd", 32'(rd_count - base), 32'd0);

    // READ from 0x000010, 4 bytes
    base = rd_count;
    frame_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, 8, rx, oa, oo);
      check($sformatf("t3_rd%0d", i), 32'(rx), 32'(exp_rd[i]));
    end
    frame_end();
    check("t3_rd_count", 32'(rd_count - base), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_addr%0d", i), 32'(rd_log[base + i]), 32'h10 + 32'(i));

    // READ across the top of the 16-bit address space
    base = rd_count;
    frame_begin();
    send(8'h03); send(8'h00); send(8'hFF); send(8'hFF);
    xfer(8'h00, 8, rx, oa, oo);
    check("t4_rd0", 32'(rx), 32'hA5);
    xfer(8'h00, 8, rx, oa, oo);
    check("t4_rd1", 32'(rx), 32'h5A);
    frame_end();
    check("t4_rd_count", 32'(rd_count - base), 32'd3);
    check("t4_addr0", 32'(rd_log[base]), 32'hFFFF);
    check("t4_addr1", 32'(rd_log[base + 1]), 32'h0000);

    // Unknown opcode, then RDSR
    base = rd_count;
    frame_begin();
    send(8'h06);
    for (int i = 0; i < 2; i++) begin
      xfer(8'hA5, 8, rx, oa, oo);
      check($sformatf("t5_ign_oe%0d", i), 32'(oo), 32'd0);
    end
    frame_end();
    check("t5_no_rd", 32'(rd_count - base), 32'd0);
    frame_begin();
    send(8'h05);
    for (int i = 0; i < 2; i++) begin
      xfer(8'h00, 8, rx, oa, oo);
      check($sformatf("t5_sr%0d", i), 32'(rx), 32'h00);
      check($sformatf("t5_sr_oe%0d", i), 32'(oa), 32'd1);
    end
    frame_end();

    // Aborted address at the minimum SCK phase, then a clean READ from 0
    PH = 4;
    base = rd_count;
    frame_begin();
    send(8'h03);
    xfer(8'hFF, 5, rx, oa, oo);
    frame_end();
    check("t6_abort_no_rd", 32'(rd_count - base), 32'd0);
    base = rd_count;
    frame_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    xfer(8'h00, 8, rx, oa, oo);
    check("t6_rd0", 32'(rx), 32'h5A);
    frame_end();
    check("t6_addr0", 32'(rd_log[base]), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
